sobel_window_ctrl: RTL and testbench
====================================

Name: sobel_window_ctrl

Overview:
- Raster-scan frame sequencer for the sobel datapath.
- Accepts a pixel stream with a valid/ready handshake and keeps two line buffers plus column shift registers.
- Drives the eight neighbour ports p0..p3 and p5..p8 of an external sobel instance, tracks sobel's one-register latency, and returns tagged results.
- Emits results only for interior pixels. Signals frame completion.

Parameters:
- IMG_W, 64, pixels per line (>=3).
- IMG_H, 48, lines per frame (>=3).
- CW, $clog2(IMG_W), column counter/tag width.
- RW, $clog2(IMG_H), row counter/tag width.

Ports:
- clk  in  1  system clock, all flops rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  pixel available.
- in_ready  out  1  block can accept a pixel.
- in_sof  in  1  marks first pixel (0,0) of a frame; qualified by in_valid.
- in_pix  in  8  pixel value.
- p0,p1,p2,p3,p5,p6,p7,p8  out  9 each  window to sobel, zero-extended ({1'b0,pix}). p0/p1/p2 = top row left→right, p3/p5 = middle row left/right, p6/p7/p8 = bottom row.
- win_valid  out  1  window ports hold a new interior window.
- sobel_out  in  8  sobel result (combinational from sobel's internal gx/gy registers).
- res_valid  out  1  one-cycle result strobe.
- res_pix  out  8  captured sobel_out.
- res_col  out  CW  centre column of the result.
- res_row  out  RW  centre row of the result.
- frame_done  out  1  one-cycle pulse after the last result of a frame.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. p*=0, win_valid=0, res_valid=0, res_pix=0, res_col=0, res_row=0, frame_done=0, busy=0. Counters and pipeline valids cleared. Line-buffer contents are don't-care.
- FSM states:
  - IDLE: in_ready=1. Non-sof pixels are accepted and dropped. An accepted in_sof pixel is stored as (0,0) → FILL.
  - FILL: rows 0–1, no windows. Accepting (1,IMG_W-1) → RUN.
  - RUN: a window is generated for every accepted (r,c) with c>=2. Accepting (IMG_H-1,IMG_W-1) → DRAIN.
  - DRAIN: in_ready=0 for exactly 2 cycles while the pipeline empties. Then frame_done=1 for 1 cycle and → IDLE.
- Accept: a pixel is accepted on an edge where in_valid&in_ready. Each accept advances col; at IMG_W-1, col wraps to 0 and row increments. in_valid gaps are allowed in any state, with no effect.
- Storage: lb1[c] = row r-1, lb2[c] = row r-2. sh1/sh2 = the last two pixels of the current row.
- Window: on accept of (r,c) with r>=2 and c>=2:
  - p8=in_pix, p7=sh1, p6=sh2.
  - p5=lb1[c], p3=lb1[c-2].
  - p2=lb2[c], p1=lb2[c-1], p0=lb2[c-2].
  - Tag = (r-1,c-1).
  - Column-row registers shift in the same edge.
- Pipeline:
  - Accept at edge k → p*/win_valid registered at edge k; win_valid is high for one cycle unless another window follows.
  - Edge k+1: sobel captures gx/gy.
  - Edge k+2: res_pix<=sobel_out, res_valid=1 with the matching tag.
  - Total: 2 cycles from window to result; tags delayed by a 2-deep shift register.
- Window ports hold their last value when win_valid=0.
- Results per frame: exactly (IMG_W-2)*(IMG_H-2), in raster order. No result for border centres.
- in_sof while busy (any state): the current frame is abandoned. In-flight results (at most 2) still emit with their old tags. The pixel becomes the new (0,0), state → FILL, and no frame_done is issued for the abandoned frame.
- in_sof on a non-(0,0) position is the only resync mechanism. A missing sof at a frame boundary leaves the block in IDLE.
- There is no output backpressure; the consumer must take res_valid every cycle.

Test Plan:
- IMG_W=8, IMG_H=6, flat image of 50s streamed at in_valid=1 → 24 res_valid pulses, all res_pix=0, tags (1,1)..(4,6) in raster order, then one frame_done pulse; in_ready is low for exactly 2 cycles before frame_done.
- Same size, cols 0–3=0 and cols 4–7=10, with the real sobel attached → res_pix=0x28 for res_col 3 and 4 on every row, 0 elsewhere.
- Ramp pixel value = 8*r+c with random in_valid gaps (50%) → the window for tag (2,3) is p0=10, p1=11, p2=12, p3=18, p5=20, p6=26, p7=27, p8=28; the result sequence is identical to the gapless run.
- Pixels without in_sof while IDLE, then sof → the leading pixels are ignored, busy rises on sof, and there are 24 results.
- in_sof injected at (3,5) of frame 1 → ≤2 trailing old-tag results, no frame_done, and the new frame completes with 24 results and a frame_done.
- rst_n pulsed low mid-RUN → all outputs read 0 asynchronously; after release, a fresh sof frame produces the correct 24 results.

Source files
------------

// File: rtl/sobel_window_ctrl.sv
// Raster-scan window sequencer for an external sobel instance.
// Buffers two previous lines, forms the 3x3 neighbourhood for every interior
// pixel, follows sobel's one-register latency and returns tagged results.
module sobel_window_ctrl #(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 48,
    parameter int unsigned CW    = $clog2(IMG_W),
    parameter int unsigned RW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    // pixel stream
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sof,
    input  logic [7:0]    in_pix,
    // window to sobel
    output logic [8:0]    p0,
    output logic [8:0]    p1,
    output logic [8:0]    p2,
    output logic [8:0]    p3,
    output logic [8:0]    p5,
    output logic [8:0]    p6,
    output logic [8:0]    p7,
    output logic [8:0]    p8,
    output logic          win_valid,
    // result from sobel
    input  logic [7:0]    sobel_out,
    output logic          res_valid,
    output logic [7:0]    res_pix,
    output logic [CW-1:0] res_col,
    output logic [RW-1:0] res_row,
    output logic          frame_done,
    output logic          busy
);

    localparam int unsigned PIX_W = 8;
    localparam int unsigned WIN_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // raster position of the next pixel to be accepted
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          drain_cnt;

    // line buffers: lb1 = previous row, lb2 = row before that
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];

    // column shift registers for current (sh), middle (mid) and top (top) rows
    logic [PIX_W-1:0] sh1;
    logic [PIX_W-1:0] sh2;
    logic [PIX_W-1:0] mid1;
    logic [PIX_W-1:0] mid2;
    logic [PIX_W-1:0] top1;
    logic [PIX_W-1:0] top2;

    // tag pipeline: stage 1 travels with the window, stage 2 with sobel's registers
    logic [CW-1:0] win_col;
    logic [RW-1:0] win_row;
    logic          s2_valid;
    logic [CW-1:0] s2_col;
    logic [RW-1:0] s2_row;

    // handshake / control decode
    logic          accept_c;
    logic          store_c;
    logic          win_fire_c;
    logic          last_col_c;
    logic [CW-1:0] wr_col_c;

    // Control decode and next-state logic
    always_comb begin
        next_state = state;
        accept_c   = in_valid && in_ready;
        store_c    = accept_c && (in_sof || (state != IDLE));
        last_col_c = (col == CW'(IMG_W - 1));
        wr_col_c   = in_sof ? '0 : col;
        win_fire_c = accept_c && !in_sof && (state == RUN) && (col >= CW'(2));

        case (state)
            IDLE: begin
                if (accept_c && in_sof) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (accept_c) begin
                    if (in_sof) begin
                        next_state = FILL;
                    end else if ((row == RW'(1)) && last_col_c) begin
                        next_state = RUN;
                    end
                end
            end
            RUN: begin
                if (accept_c) begin
                    if (in_sof) begin
                        next_state = FILL;
                    end else if ((row == RW'(IMG_H - 1)) && last_col_c) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Raster counters and drain timer; a sof pixel is always position (0,0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            drain_cnt <= 1'b0;
        end else begin
            if (store_c) begin
                if (in_sof) begin
                    col <= CW'(1);
                    row <= '0;
                end else if (last_col_c) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    // Pixel storage; contents are only ever read after being written this frame
    always_ff @(posedge clk) begin
        if (store_c) begin
            lb1[wr_col_c] <= in_pix;
            lb2[wr_col_c] <= lb1[wr_col_c];
            sh1           <= in_pix;
            sh2           <= sh1;
            mid1          <= lb1[wr_col_c];
            mid2          <= mid1;
            top1          <= lb2[wr_col_c];
            top2          <= top1;
        end
    end

    // Window ports and their tag; ports hold between windows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0        <= '0;
            p1        <= '0;
            p2        <= '0;
            p3        <= '0;
            p5        <= '0;
            p6        <= '0;
            p7        <= '0;
            p8        <= '0;
            win_valid <= 1'b0;
            win_col   <= '0;
            win_row   <= '0;
        end else begin
            win_valid <= win_fire_c;
            if (win_fire_c) begin
                p8      <= WIN_W'(in_pix);
                p7      <= WIN_W'(sh1);
                p6      <= WIN_W'(sh2);
                p5      <= WIN_W'(lb1[col]);
                p3      <= WIN_W'(mid2);
                p2      <= WIN_W'(lb2[col]);
                p1      <= WIN_W'(top1);
                p0      <= WIN_W'(top2);
                win_col <= col - CW'(1);
                win_row <= row - RW'(1);
            end
        end
    end

    // Tag stage aligned with sobel's internal gx/gy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_col   <= '0;
            s2_row   <= '0;
        end else begin
            s2_valid <= win_valid;
            s2_col   <= win_col;
            s2_row   <= win_row;
        end
    end

    // Result capture, frame completion and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid  <= 1'b0;
            res_pix    <= '0;
            res_col    <= '0;
            res_row    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            res_valid <= s2_valid;
            if (s2_valid) begin
                res_pix <= sobel_out;
                res_col <= s2_col;
                res_row <= s2_row;
            end
            frame_done <= (state == DRAIN) && drain_cnt;
            busy       <= (next_state != IDLE);
            in_ready   <= (next_state != DRAIN);
        end
    end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on an 8x6 frame with a behavioural sobel.
module tb_sobel_window_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 6;
    localparam int unsigned CW = 3;
    localparam int unsigned RW = 3;
    localparam int NPIX = 48;
    localparam int NRES = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic          in_sof;
    logic [7:0]    in_pix;
    logic [8:0]    p0, p1, p2, p3, p5, p6, p7, p8;
    logic          win_valid;
    logic [7:0]    sobel_out;
    logic          res_valid;
    logic [7:0]    res_pix;
    logic [CW-1:0] res_col;
    logic [RW-1:0] res_row;
    logic          frame_done;
    logic          busy;

    sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pix(in_pix),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
        .win_valid(win_valid), .sobel_out(sobel_out),
        .res_valid(res_valid), .res_pix(res_pix), .res_col(res_col), .res_row(res_row),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // behavioural sobel: gradients registered, magnitude |gx|+|gy| saturated
    int gx = 0;
    int gy = 0;
    always @(posedge clk) begin
        gx <= (int'(p2) + 2 * int'(p5) + int'(p8)) - (int'(p0) + 2 * int'(p3) + int'(p6));
        gy <= (int'(p6) + 2 * int'(p7) + int'(p8)) - (int'(p0) + 2 * int'(p1) + int'(p2));
    end
    always_comb begin
        int mag;
        mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
        sobel_out = (mag > 255) ? 8'd255 : 8'(mag);
    end

    typedef struct { int col; int row; int pix; } res_t;
    typedef struct { int q0; int q1; int q2; int q3; int q5; int q6; int q7; int q8; } win_t;

    res_t res_q[$];
    win_t win_q[$];
    int   n_chk = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    int   lo_streak = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // output monitor on the falling edge
    always @(negedge clk) begin
        if (res_valid) res_q.push_back('{int'(res_col), int'(res_row), int'(res_pix)});
        if (win_valid) win_q.push_back('{int'(p0), int'(p1), int'(p2), int'(p3),
                                         int'(p5), int'(p6), int'(p7), int'(p8)});
        if (frame_done) begin
            done_cnt++;
            chk("ready_low_before_done", lo_streak, 2);
        end
        lo_streak = in_ready ? 0 : lo_streak + 1;
    end

    function automatic int pix_val(input int kind, input int r, input int c);
        case (kind)
            0:       return 50;
            1:       return (c < 4) ? 0 : 10;
            default: return 8 * r + c;
        endcase
    endfunction

    function automatic int exp_res(input int kind, input int c);
        case (kind)
            0:       return 0;
            1:       return ((c == 3) || (c == 4)) ? 40 : 0;
            default: return 72;
        endcase
    endfunction

    task automatic send_pix(input int pix, input bit sof);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_pix   = 8'(pix);
        in_sof   = sof;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", guard, 0);
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int kind, input int gap_pct, input int first, input int last);
        for (int i = first; i < last; i++) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_sof   = 1'b0;
            end
            send_pix(pix_val(kind, i / int'(W), i % int'(W)), i == 0);
        end
        idle_in();
    endtask

    task automatic wait_done(input string tag, input int start);
        int cyc;
        cyc = 0;
        while (done_cnt == start && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        chk(tag, done_cnt - start, 1);
    endtask

    task automatic check_raster(input string tag, input int kind);
        chk({tag, "_count"}, res_q.size(), NRES);
        for (int i = 0; i < NRES; i++) begin
            if (i < res_q.size()) begin
                chk({tag, "_col"}, res_q[i].col, 1 + i % 6);
                chk({tag, "_row"}, res_q[i].row, 1 + i / 6);
                chk({tag, "_pix"}, res_q[i].pix, exp_res(kind, 1 + i % 6));
            end
        end
    endtask

    initial begin
        int d;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pix   = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_p0", int'(p0), 0);
        chk("rst_p8", int'(p8), 0);
        chk("rst_win_valid", int'(win_valid), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // flat frame
        res_q.delete(); d = done_cnt;
        send_frame(0, 0, 0, NPIX);
        wait_done("flat_done", d);
        check_raster("flat", 0);

        // vertical edge
        res_q.delete(); d = done_cnt;
        send_frame(1, 0, 0, NPIX);
        wait_done("edge_done", d);
        check_raster("edge", 1);

        // ramp, gapless then with 50% gaps
        res_q.delete(); d = done_cnt;
        send_frame(2, 0, 0, NPIX);
        wait_done("ramp_done", d);
        check_raster("ramp", 2);

        res_q.delete(); win_q.delete(); d = done_cnt;
        send_frame(2, 50, 0, NPIX);
        wait_done("gap_done", d);
        check_raster("gap", 2);
        chk("gap_win_count", win_q.size(), NRES);
        if (win_q.size() > 8) begin
            chk("win23_p0", win_q[8].q0, 10);
            chk("win23_p1", win_q[8].q1, 11);
            chk("win23_p2", win_q[8].q2, 12);
            chk("win23_p3", win_q[8].q3, 18);
            chk("win23_p5", win_q[8].q5, 20);
            chk("win23_p6", win_q[8].q6, 26);
            chk("win23_p7", win_q[8].q7, 27);
            chk("win23_p8", win_q[8].q8, 28);
        end

        // non-sof pixels while idle are dropped
        res_q.delete(); d = done_cnt;
        for (int i = 0; i < 5; i++) send_pix(99, 1'b0);
        idle_in();
        repeat (2) @(negedge clk);
        chk("idle_drop_busy", int'(busy), 0);
        chk("idle_drop_ready", int'(in_ready), 1);
        send_pix(50, 1'b1);
        idle_in();
        chk("sof_busy", int'(busy), 1);
        send_frame(0, 0, 1, NPIX);
        wait_done("idle_done", d);
        check_raster("idle", 0);

        // sof at (3,5) abandons the ramp frame
        res_q.delete(); d = done_cnt;
        send_frame(2, 0, 0, 29);
        send_frame(0, 0, 0, NPIX);
        wait_done("resync_done", d);
        chk("resync_count", res_q.size(), 9 + NRES);
        if (res_q.size() >= 9 + NRES) begin
            chk("resync_old_col", res_q[8].col, 3);
            chk("resync_old_row", res_q[8].row, 2);
            chk("resync_old_pix", res_q[8].pix, 72);
            chk("resync_new_col", res_q[9].col, 1);
            chk("resync_new_row", res_q[9].row, 1);
            chk("resync_new_pix", res_q[9].pix, 0);
            chk("resync_last_col", res_q[32].col, 6);
            chk("resync_last_row", res_q[32].row, 4);
        end

        // asynchronous reset mid-run
        send_frame(2, 0, 0, 30);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_p0", int'(p0), 0);
        chk("arst_p8", int'(p8), 0);
        chk("arst_win_valid", int'(win_valid), 0);
        chk("arst_res_valid", int'(res_valid), 0);
        chk("arst_res_pix", int'(res_pix), 0);
        chk("arst_res_col", int'(res_col), 0);
        chk("arst_res_row", int'(res_row), 0);
        chk("arst_frame_done", int'(frame_done), 0);
        chk("arst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        res_q.delete(); d = done_cnt;
        send_frame(0, 0, 0, NPIX);
        wait_done("post_rst_done", d);
        check_raster("post_rst", 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
